// File: rtl/conv_engine.sv
// conv_engine: 3x3 Gaussian smoothing engine, 3-stage pipeline with a global stall and a per-frame output counter.
// Define CONV_THRESH_EN to binarise the result against THRESHOLD (default build outputs the raw result).
module conv_engine #(
    parameter int PIXELS_PER_FRAME = 15876,
    parameter int THRESHOLD        = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] in_pixel_data,
    input  logic        in_pixel_data_valid,
    output logic        in_ready,
    output logic [7:0]  out_pixel_data,
    output logic        out_pixel_data_valid,
    input  logic        out_ready,
    output logic [15:0] pixel_count,
    output logic        frame_done
);

    localparam logic [15:0] PPF_C = 16'(PIXELS_PER_FRAME);

`ifdef CONV_THRESH_EN
    localparam logic [8:0] THRESH_C = 9'(THRESHOLD);
`else
    logic [8:0] thresh_unused_s;
    assign thresh_unused_s = 9'(THRESHOLD);
`endif

    function automatic logic [7:0] px(input logic [71:0] win, input int k);
        return win[8*k +: 8];
    endfunction

    logic        adv_s;
    logic        out_hs_s;
    logic [11:0] total_s;
    logic [11:0] rounded_s;
    logic [7:0]  result_s;
    logic [7:0]  filt_s;

    logic        s1_valid_q, s1_valid_d;
    logic [9:0]  s1_term_q [9];
    logic [9:0]  s1_term_d [9];
    logic        s2_valid_q, s2_valid_d;
    logic [9:0]  s2_row_q [3];
    logic [9:0]  s2_row_d [3];
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic [15:0] count_q, count_d;
    logic        frame_done_q, frame_done_d;

    assign adv_s    = out_ready | ~out_valid_q;
    assign out_hs_s = out_valid_q & out_ready;
    assign in_ready = adv_s;

    // Datapath arithmetic. The middle row is kept at half weight so every row sum fits
    // in 10 bits; its factor of two is restored when the rows are totalled.
    always_comb begin
        total_s   = {2'b00, s2_row_q[0]} + {1'b0, s2_row_q[1], 1'b0} + {2'b00, s2_row_q[2]};
        rounded_s = total_s + 12'd8;
        result_s  = 8'(rounded_s >> 4);
`ifdef CONV_THRESH_EN
        filt_s    = ({1'b0, result_s} >= THRESH_C) ? 8'd255 : 8'd0;
`else
        filt_s    = result_s;
`endif
    end

    // Pipeline next state: all stages advance together or all hold.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_term_d   = s1_term_q;
        s2_valid_d  = s2_valid_q;
        s2_row_d    = s2_row_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (adv_s) begin
            s1_valid_d   = in_pixel_data_valid;
            s1_term_d[0] = {2'b00, px(in_pixel_data, 0)};
            s1_term_d[1] = {1'b0,  px(in_pixel_data, 1), 1'b0};
            s1_term_d[2] = {2'b00, px(in_pixel_data, 2)};
            s1_term_d[3] = {2'b00, px(in_pixel_data, 3)};
            s1_term_d[4] = {1'b0,  px(in_pixel_data, 4), 1'b0};
            s1_term_d[5] = {2'b00, px(in_pixel_data, 5)};
            s1_term_d[6] = {2'b00, px(in_pixel_data, 6)};
            s1_term_d[7] = {1'b0,  px(in_pixel_data, 7), 1'b0};
            s1_term_d[8] = {2'b00, px(in_pixel_data, 8)};
            s2_valid_d   = s1_valid_q;
            s2_row_d[0]  = s1_term_q[0] + s1_term_q[1] + s1_term_q[2];
            s2_row_d[1]  = s1_term_q[3] + s1_term_q[4] + s1_term_q[5];
            s2_row_d[2]  = s1_term_q[6] + s1_term_q[7] + s1_term_q[8];
            out_valid_d  = s2_valid_q;
            if (s2_valid_q) begin
                out_data_d = filt_s;
            end else begin
                out_data_d = out_data_q;
            end
        end else begin
            s1_valid_d  = s1_valid_q;
            out_valid_d = out_valid_q;
        end
    end

    // Frame accounting on each output handshake.
    always_comb begin
        count_d      = count_q;
        frame_done_d = 1'b0;
        if (out_hs_s) begin
            if (count_q + 16'd1 == PPF_C) begin
                count_d      = 16'd0;
                frame_done_d = 1'b1;
            end else begin
                count_d      = count_q + 16'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    // State registers; reset wins over any concurrent handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 8'd0;
            count_q      <= 16'd0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                s1_term_q[k] <= 10'd0;
            end
            for (int r = 0; r < 3; r++) begin
                s2_row_q[r] <= 10'd0;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_term_q    <= s1_term_d;
            s2_valid_q   <= s2_valid_d;
            s2_row_q     <= s2_row_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_pixel_data       = out_data_q;
    assign out_pixel_data_valid = out_valid_q;
    assign pixel_count          = count_q;
    assign frame_done           = frame_done_q;

endmodule

// File: tb/tb_conv_engine.sv
// tb_conv_engine: directed vector table plus hand-written stall, frame, reset and throughput sequences.
module tb_conv_engine;
    localparam int PPF = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [71:0] in_data = 72'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] pixel_count;
    logic        frame_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [71:0] win;
        logic [7:0]  exp;
    } vec_t;
    vec_t tbl[10];

    logic [7:0]  got_q[$];
    int          cyc_q[$];
    logic [15:0] cnt_q[$];
    logic        fd_q[$];
    int          fd_total;

    always #5 clk = ~clk;

    conv_engine #(.PIXELS_PER_FRAME(PPF), .THRESHOLD(128)) dut (
        .clk(clk), .reset(reset),
        .in_pixel_data(in_data), .in_pixel_data_valid(in_valid), .in_ready(in_ready),
        .out_pixel_data(out_data), .out_pixel_data_valid(out_valid), .out_ready(out_ready),
        .pixel_count(pixel_count), .frame_done(frame_done)
    );

    function automatic logic [7:0] post(input logic [7:0] raw);
`ifdef CONV_THRESH_EN
        return (raw >= 8'd128) ? 8'd255 : 8'd0;
`else
        return raw;
`endif
    endfunction

    function automatic logic [7:0] ref_px(input logic [71:0] w);
        int wt[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
        int s = 0;
        for (int k = 0; k < 9; k++) s += wt[k] * int'(w[8*k +: 8]);
        return post(8'((s + 8) >> 4));
    endfunction

    function automatic logic [71:0] mkwin(input int i);
        logic [71:0] w = 72'd0;
        w[39:32] = 8'(8 * (i + 1));
        w[7:0]   = 8'(3 * i);
        w[71:64] = 8'(i);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic stream(input int n, input int st, input int sl, input int ncyc);
        int idx = 0;
        logic hs_prev = 1'b0;
        got_q.delete(); cyc_q.delete(); cnt_q.delete(); fd_q.delete();
        fd_total = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (hs_prev) begin
                cnt_q.push_back(pixel_count);
                fd_q.push_back(frame_done);
            end
            fd_total += frame_done ? 1 : 0;
            out_ready = (c >= st && c < st + sl) ? 1'b0 : 1'b1;
            if (idx < n) begin
                in_data = mkwin(idx); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) idx++;
            hs_prev = out_valid && out_ready;
            if (hs_prev) begin
                got_q.push_back(out_data);
                cyc_q.push_back(c);
            end
            if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        logic [2:0] lat;
        int seen;
        logic [15:0] exp_cnt[6] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2};
        logic        exp_fd[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        tbl[0] = '{{9{8'hFF}}, 8'd255};
        tbl[1] = '{72'd0, 8'd0};
        tbl[2] = '{72'h80_0000_0000, 8'd32};
        tbl[3] = '{72'hFF, 8'd16};
        tbl[4] = '{72'h1000, 8'd2};
        tbl[5] = '{72'h0700_0000, 8'd1};
        tbl[6] = '{{9{8'h10}}, 8'd16};
        tbl[7] = '{72'hFF_0000_0000, 8'd64};
        tbl[8] = '{{8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10, 8'h00}, 8'd64};
        tbl[9] = '{{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF}, 8'd64};

        // Reset state, with a valid window offered throughout reset.
        in_data = {9{8'hFF}}; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_pixel_count", 32'(pixel_count), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0; in_valid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += out_valid ? 1 : 0;
        end
        check("rst_no_stale_output", 32'(seen), 32'd0);

        // Table: single windows, exact 3-cycle latency and filtered value.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_data = tbl[i].win; in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(negedge clk);
            in_valid = 1'b0;
            lat[2] = out_valid;
            @(negedge clk);
            lat[1] = out_valid;
            @(negedge clk);
            lat[0] = out_valid;
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(post(tbl[i].exp)));
        end

        // Five windows with a 4-cycle downstream stall mid-stream.
        do_reset();
        stream(5, 4, 4, 30);
        check("stall_count", 32'(got_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check($sformatf("stall_out%0d", i), 32'(got_q[i]), 32'(ref_px(mkwin(i))));

        // Frame wrap with PPF=4 over six outputs.
        do_reset();
        stream(6, 100, 0, 15);
        check("frame_hs_count", 32'(cnt_q.size()), 32'd6);
        for (int i = 0; i < 6 && i < cnt_q.size(); i++) begin
            check($sformatf("frame_cnt%0d", i), 32'(cnt_q[i]), 32'(exp_cnt[i]));
            check($sformatf("frame_done%0d", i), 32'(fd_q[i]), 32'(exp_fd[i]));
        end
        check("frame_done_pulses", 32'(fd_total), 32'd1);

        // Reset with three windows in flight and an output handshake pending.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_data = mkwin(i); in_valid = 1'b1;
        end
        @(negedge clk);
        check("inflight_valid", 32'(out_valid), 32'd1);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("inflight_rst_valid", 32'(out_valid), 32'd0);
        check("inflight_rst_count", 32'(pixel_count), 32'd0);
        check("inflight_rst_data", 32'(out_data), 32'd0);
        reset = 1'b0;
        #1;
        check("inflight_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += (out_valid || frame_done) ? 1 : 0;
        end
        check("inflight_no_stale", 32'(seen), 32'd0);

        // Throughput: 20 windows back to back.
        do_reset();
        stream(20, 100, 0, 30);
        check("tput_count", 32'(got_q.size()), 32'd20);
        if (got_q.size() == 20) begin
            check("tput_span", 32'(cyc_q[19] - cyc_q[0]), 32'd19);
            for (int i = 0; i < 20; i++)
                check($sformatf("tput_out%0d", i), 32'(got_q[i]), 32'(ref_px(mkwin(i))));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter PIXELS_PER_FRAME, default 15876 (126x126), SHALL set the number of output handshakes per frame.
REQ-002 Parameter THRESHOLD, default 128, SHALL set the binarisation level used only when CONV_THRESH_EN is defined.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port in_pixel_data  input  72  SHALL carry a 3x3 window, row-major; pixel k in bits [8k+7:8k], k=0 top-left, k=4 centre.
REQ-006 Port in_pixel_data_valid  input  1  SHALL qualify in_pixel_data.
REQ-007 Port in_ready  output  1  SHALL indicate that a window is accepted this cycle if valid is high.
REQ-008 Port out_pixel_data  output  8  SHALL carry the filtered pixel.
REQ-009 Port out_pixel_data_valid  output  1  SHALL qualify out_pixel_data.
REQ-010 Port out_ready  input  1  SHALL be the downstream acceptance signal.
REQ-011 Port pixel_count  output  16  SHALL give the number of output handshakes completed in the current frame.
REQ-012 Port frame_done  output  1  SHALL pulse for one cycle after the last output of a frame.

Function
REQ-013 Kernel SHALL be fixed Gaussian weights [1,2,1; 2,4,2; 1,2,1], implemented with shifts and adds, no multipliers.
REQ-014 Result SHALL be (weighted sum + 8) >> 4; sum width 12 bits; result always 0..255, no saturation needed.
REQ-015 Pipeline SHALL have 3 register stages: S1 weighted terms, S2 three row sums (10 bits each), S3 total, round, shift into the output register.
REQ-016 Latency SHALL be 3 cycles from input handshake to out_pixel_data_valid, with no stalls.
REQ-017 Global advance enable SHALL be out_ready OR NOT out_pixel_data_valid; in_ready SHALL equal this enable combinationally.
REQ-018 When enable is low, every stage register and its valid bit SHALL hold; no data SHALL be lost or duplicated.
REQ-019 Input handshake: in_pixel_data_valid AND in_ready; valid low with enable high SHALL insert a bubble (stage valid 0).
REQ-020 Output handshake: out_pixel_data_valid AND out_ready SHALL increment pixel_count.
REQ-021 When an output handshake brings pixel_count to PIXELS_PER_FRAME, pixel_count SHALL become 0 and frame_done SHALL be 1 in the next cycle only.
REQ-022 Throughput SHALL be one window per cycle while out_ready stays high.
REQ-023 Simultaneous input handshake and output handshake SHALL both complete in the same cycle.

Reset
REQ-024 While reset is high: all stage valid bits 0, out_pixel_data 0, out_pixel_data_valid 0, pixel_count 0, frame_done 0.
REQ-025 Reset asserted mid-frame SHALL discard in-flight windows and the partial count; in_ready SHALL be 1 in the first cycle after reset.
REQ-026 Reset SHALL take priority over any concurrent handshake.

Configuration
REQ-027 Macro CONV_THRESH_EN defined: out_pixel_data SHALL be 255 if the result is >= THRESHOLD, else 0; latency unchanged.
REQ-028 Macro CONV_THRESH_EN undefined: out_pixel_data SHALL be the raw result; THRESHOLD unused.

Verification
REQ-029 All 9 pixels 0xFF, out_ready=1 -> out_pixel_data=255 exactly 3 cycles after accept; all pixels 0x00 -> 0.
REQ-030 Centre pixel 0x80 and others 0 -> (512+8)>>4 = 32 (0x20); with CONV_THRESH_EN and THRESHOLD=128 -> 0.
REQ-031 Stream 5 distinct windows, drop out_ready for 4 cycles mid-stream -> in_ready low while output held, all 5 results in order, none duplicated.
REQ-032 PIXELS_PER_FRAME=4, 6 outputs accepted -> frame_done single pulse after 4th, pixel_count 1,2,3,0,1,2.
REQ-033 Reset asserted with 3 windows in flight -> out_pixel_data_valid=0 and pixel_count=0 next cycle, no stale output after release.
REQ-034 Continuous valid input with out_ready=1 for 20 cycles -> 20 outputs on 20 consecutive cycles.
